// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: address width, zero register and pending-write counter types.
// Used by the read-side scoreboard and the write-address control.
package reg_file_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int MAX_PEND = 3;
    localparam int CNT_W    = $clog2(MAX_PEND + 1);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;

    localparam reg_addr_t ZERO_REG = '0;
    localparam pend_cnt_t PEND_MAX = pend_cnt_t'(MAX_PEND);

endpackage

// File: rtl/reg_pend_counter.sv
// Outstanding-write counter for one register: counts up on issue, down on writeback,
// saturates at PEND_MAX and flags a writeback that arrives with nothing pending.
module reg_pend_counter
    import reg_file_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      inc,
    input  logic      dec,
    output pend_cnt_t cnt,
    output logic      nonzero,
    output logic      underflow
);

    logic dec_ok;

    assign dec_ok    = dec && (cnt != '0);
    assign nonzero   = (cnt != '0);
    assign underflow = dec && (cnt == '0);

    // NOTE: non-blocking assignments keep every counter updating from the same pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc && !dec_ok && (cnt != PEND_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec_ok && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_read_scoreboard.sv
// Decode-side scoreboard: stalls on pending source writes, registers read addresses on accept.
// Optional macro REG_SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback release a source.
module reg_read_scoreboard
    import reg_file_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_rs_used,
    input  logic              issue_rt_used,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic              issue_wen,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_waddr,
    output logic              stall,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rf_raddr_rs,
    output logic [ADDR_W-1:0] rf_raddr_rt,
    output logic              pend_err
);

    pend_cnt_t             cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   nonzero;
    logic [NUM_REGS-1:0]   underflow;
    logic [NUM_REGS-1:1]   inc;
    logic [NUM_REGS-1:1]   dec;
    logic                  accept;
    logic                  rs_wait;
    logic                  rt_wait;
    logic                  dest_full;

    // Register 0 is hard-wired zero, so it never has a counter.
    assign cnt[0]       = '0;
    assign nonzero[0]   = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        assign inc[r] = accept && issue_wen && (issue_waddr == reg_addr_t'(r));
        assign dec[r] = wb_valid && (wb_waddr == reg_addr_t'(r));

        reg_pend_counter u_cnt (
            .clock     (clock),
            .reset_n   (reset_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .cnt       (cnt[r]),
            .nonzero   (nonzero[r]),
            .underflow (underflow[r])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rs_wait   = issue_rs_used && nonzero[issue_rs];
        rt_wait   = issue_rt_used && nonzero[issue_rt];
        dest_full = issue_wen && (cnt[issue_waddr] == PEND_MAX);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        // The last outstanding write lands this cycle; the register file forwards it.
        if (wb_valid && (wb_waddr == issue_rs) && (cnt[issue_rs] == pend_cnt_t'(1))) rs_wait = 1'b0;
        if (wb_valid && (wb_waddr == issue_rt) && (cnt[issue_rt] == pend_cnt_t'(1))) rt_wait = 1'b0;
`endif
        stall = issue_valid && (rs_wait || rt_wait || dest_full);
    end

    assign accept = issue_valid && !stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid    <= 1'b0;
            rf_raddr_rs <= '0;
            rf_raddr_rt <= '0;
            pend_err    <= 1'b0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                rf_raddr_rs <= issue_rs;
                rf_raddr_rt <= issue_rt;
            end
            if (|underflow) pend_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Self-checking bench for reg_read_scoreboard: directed vector table, reset corner case,
// and randomized traffic against a counter-array reference model.
module tb_reg_read_scoreboard;
    import reg_file_pkg::*;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              issue_valid, issue_rs_used, issue_rt_used, issue_wen, wb_valid;
    logic [ADDR_W-1:0] issue_rs, issue_rt, issue_waddr, wb_waddr;
    logic              stall, rd_valid, pend_err;
    logic [ADDR_W-1:0] rf_raddr_rs, rf_raddr_rt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    reg_read_scoreboard dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rs_used (issue_rs_used),
        .issue_rt_used (issue_rt_used),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_wen     (issue_wen),
        .issue_waddr   (issue_waddr),
        .wb_valid      (wb_valid),
        .wb_waddr      (wb_waddr),
        .stall         (stall),
        .rd_valid      (rd_valid),
        .rf_raddr_rs   (rf_raddr_rs),
        .rf_raddr_rt   (rf_raddr_rt),
        .pend_err      (pend_err)
    );

    typedef struct {
        logic       iv, rs_u, rt_u;
        logic [4:0] rs, rt;
        logic       wen;
        logic [4:0] wa;
        logic       wb;
        logic [4:0] wba;
        logic       exp_stall, exp_err;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, rs_u, rt_u, input logic [4:0] rs, rt,
                         input logic wen, input logic [4:0] wa, input logic wb,
                         input logic [4:0] wba);
        issue_valid = iv;  issue_rs_used = rs_u; issue_rt_used = rt_u;
        issue_rs = rs;     issue_rt = rt;
        issue_wen = wen;   issue_waddr = wa;
        wb_valid = wb;     wb_waddr = wba;
    endtask

    function automatic vec_t mk(logic iv, logic rs_u, logic [4:0] rs, logic rt_u, logic [4:0] rt,
                                logic wen, logic [4:0] wa, logic wb, logic [4:0] wba,
                                logic es, logic ee);
        vec_t v;
        v.iv = iv; v.rs_u = rs_u; v.rs = rs; v.rt_u = rt_u; v.rt = rt;
        v.wen = wen; v.wa = wa; v.wb = wb; v.wba = wba;
        v.exp_stall = es; v.exp_err = ee;
        return v;
    endfunction

    // Reference model state
    int         m_cnt [NUM_REGS];
    logic       m_err;
    logic [4:0] m_rs, m_rt;

    function automatic logic src_ready(logic [4:0] r, logic wb, logic [4:0] wba);
        if (m_cnt[r] == 0) return 1'b1;
        return BYP && (m_cnt[r] == 1) && wb && (wba == r);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        reset_n = 1'b1;
        @(posedge clock); #1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 1'b0; m_rs = '0; m_rt = '0;
    endtask

    initial begin
        logic [4:0] last_rs, last_rt;
        logic       exp_rd;

        // Directed table, applied from a fresh reset.
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0);     // write r8
        vecs[1]  = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0);     // read r8 while pending
        vecs[2]  = mk(1, 1, 8, 0, 0, 0, 0, 1, 8, !BYP, 0);  // same-cycle wb to r8
        vecs[3]  = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);     // r8 now free
        vecs[4]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);     // write r0 ignored
        vecs[5]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);     // read r0 never stalls
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);     // wb r0 not an error
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);     // r5 at MAX_PEND
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0);     // saturation stall
        vecs[11] = mk(1, 0, 0, 0, 0, 1, 5, 1, 5, 1, 0);     // wb frees slot, still stalls
        vecs[12] = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);     // fourth write accepted
        vecs[13] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);     // cnt9=1
        vecs[14] = mk(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0);     // inc+dec: cnt9 stays 1
        vecs[15] = mk(1, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0);     // proves r9 still pending
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);     // cnt9 -> 0
        vecs[17] = mk(1, 0, 5, 1, 9, 0, 0, 0, 0, 0, 0);     // unused pending rs ignored
        vecs[18] = mk(1, 1, 3, 0, 0, 1, 3, 0, 0, 0, 0);     // self-dependent accepted
        vecs[19] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0);     // later reader stalls
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1);    // underflow on r12
        vecs[22] = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);     // no issue: no stall, err held

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("reset_rd_valid", rd_valid, 0);
        check("reset_raddr_rs", rf_raddr_rs, 0);
        check("reset_raddr_rt", rf_raddr_rt, 0);
        check("reset_pend_err", pend_err, 0);
        check("reset_stall", stall, 0);
        #9 reset_n = 1'b1;
        @(posedge clock); #1;

        last_rs = '0; last_rt = '0;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].iv, vecs[i].rs_u, vecs[i].rt_u, vecs[i].rs, vecs[i].rt,
                  vecs[i].wen, vecs[i].wa, vecs[i].wb, vecs[i].wba);
            #2;
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            @(posedge clock); #1;
            exp_rd = vecs[i].iv && !vecs[i].exp_stall;
            if (exp_rd) begin
                last_rs = vecs[i].rs;
                last_rt = vecs[i].rt;
            end
            check($sformatf("vec%0d_rd_valid", i), rd_valid, exp_rd);
            check($sformatf("vec%0d_raddr_rs", i), rf_raddr_rs, last_rs);
            check($sformatf("vec%0d_raddr_rt", i), rf_raddr_rt, last_rt);
            check($sformatf("vec%0d_pend_err", i), pend_err, vecs[i].exp_err);
        end

        // Mid-run asynchronous reset clears outputs and tracking immediately.
        drive(1, 1, 1, 7, 6, 0, 0, 0, 0);
        @(posedge clock); #1;
        check("pre_reset_rd_valid", rd_valid, 1);
        check("pre_reset_raddr_rs", rf_raddr_rs, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rd_valid", rd_valid, 0);
        check("async_raddr_rs", rf_raddr_rs, 0);
        check("async_raddr_rt", rf_raddr_rt, 0);
        check("async_pend_err", pend_err, 0);
        @(posedge clock); #3 reset_n = 1'b1;
        @(posedge clock); #1;
        drive(1, 1, 0, 5, 0, 1, 5, 0, 0);
        #2;
        check("post_reset_r5_free", stall, 0);
        @(posedge clock); #1;
        drive(1, 0, 1, 0, 5, 0, 0, 0, 0);
        #2;
        check("post_reset_r5_pending", stall, 1);
        @(posedge clock); #1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic       iv, rs_u, rt_u, wen, wb, es;
            logic [4:0] rs, rt, wa, wba;
            iv   = ($urandom_range(0, 3) != 0);
            rs_u = $urandom_range(0, 1);
            rt_u = $urandom_range(0, 1);
            rs   = 5'($urandom_range(0, 7));
            rt   = 5'($urandom_range(0, 7));
            wen  = $urandom_range(0, 1);
            wa   = 5'($urandom_range(0, 7));
            wb   = ($urandom_range(0, 2) == 0);
            wba  = 5'($urandom_range(0, 7));
            for (int t = 0; t < 4 && m_cnt[wba] == 0; t++) wba = 5'($urandom_range(0, 7));

            es = iv && ((rs_u && !src_ready(rs, wb, wba)) ||
                        (rt_u && !src_ready(rt, wb, wba)) ||
                        (wen && m_cnt[wa] == MAX_PEND));

            drive(iv, rs_u, rt_u, rs, rt, wen, wa, wb, wba);
            #2;
            check("rand_stall", stall, es);

            if (wb && wba != 0) begin
                if (m_cnt[wba] == 0) m_err = 1'b1;
                else                 m_cnt[wba] = m_cnt[wba] - 1;
            end
            if (iv && !es) begin
                if (wen && wa != 0) m_cnt[wa] = m_cnt[wa] + 1;
                m_rs = rs;
                m_rt = rt;
            end

            @(posedge clock); #1;
            check("rand_rd_valid", rd_valid, iv && !es);
            check("rand_raddr_rs", rf_raddr_rs, m_rs);
            check("rand_raddr_rt", rf_raddr_rt, m_rt);
            check("rand_pend_err", pend_err, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
